// File: rtl/cmd_stream_processor.sv
// Command stream parser: turns the ui_in byte stream into CLEAR/PIXEL/LINE/RECT
// commands and queues them in a first-word-fall-through FIFO for the rasterizer.
module cmd_stream_processor #(
  parameter int unsigned COORD_W    = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [7:0]                       ui_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [1:0]                       out_cmd,
  output logic [COORD_W-1:0]               out_x1,
  output logic [COORD_W-1:0]               out_y1,
  output logic [COORD_W-1:0]               out_x2,
  output logic [COORD_W-1:0]               out_y2,
  output logic [COORD_W-1:0]               out_width,
  output logic [COORD_W-1:0]               out_height,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             busy,
  output logic                             err_abort,
  output logic                             err_overflow
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned ENTRY_W = 2 + 6 * COORD_W;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                      state, state_nx;
  logic [1:0]                  cmd_r, cmd_nx;
  logic [1:0]                  idx, idx_nx;
  logic [3:0][COORD_W-1:0]     fld, fld_nx;
  logic [TO_W-1:0]             tcnt, tcnt_nx;
  logic                        abort_nx;
  logic                        push;
  logic [ENTRY_W-1:0]          push_data;

  logic                        en;
  logic [1:0]                  opc;
  logic [4:0]                  prm;
  logic [COORD_W-1:0]          val;
  logic [1:0]                  last_idx;

  assign en       = ui_in[7];
  assign opc      = ui_in[6:5];
  assign prm      = ui_in[4:0];
  assign val      = prm[COORD_W-1:0];
  assign last_idx = (cmd_r == 2'b01) ? 2'd1 : 2'd3;

  // Parser state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_r     <= 2'b00;
      idx       <= 2'd0;
      fld       <= '0;
      tcnt      <= '0;
      err_abort <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cmd_r     <= cmd_nx;
      idx       <= idx_nx;
      fld       <= fld_nx;
      tcnt      <= tcnt_nx;
      err_abort <= abort_nx;
      busy      <= (state_nx == LOAD);
    end
  end

  // Next-state, field capture and command completion
  always_comb begin
    state_nx  = state;
    cmd_nx    = cmd_r;
    idx_nx    = idx;
    fld_nx    = fld;
    tcnt_nx   = tcnt;
    abort_nx  = 1'b0;
    push      = 1'b0;
    push_data = '0;
    if (en && opc != 2'b00) begin
      // An opcode always starts a new command; in LOAD it also drops the partial one.
      abort_nx = (state == LOAD);
      tcnt_nx  = '0;
      if (opc == 2'b01 && prm == 5'h1F) begin
        state_nx = IDLE;
        push     = 1'b1;
      end else begin
        state_nx  = LOAD;
        cmd_nx    = opc;
        idx_nx    = 2'd1;
        fld_nx[0] = val;
      end
    end else if (state == LOAD) begin
      if (en) begin
        tcnt_nx     = '0;
        fld_nx[idx] = val;
        if (idx == last_idx) begin
          state_nx = IDLE;
          push     = 1'b1;
          case (cmd_r)
            2'b01:   push_data = {cmd_r, fld_nx[0], fld_nx[1], {(4*COORD_W){1'b0}}};
            2'b10:   push_data = {cmd_r, fld_nx[0], fld_nx[1], fld_nx[2], fld_nx[3],
                                  {(2*COORD_W){1'b0}}};
            default: push_data = {cmd_r, fld_nx[0], fld_nx[1], {(2*COORD_W){1'b0}},
                                  fld_nx[2], fld_nx[3]};
          endcase
        end else begin
          idx_nx = idx + 2'd1;
        end
      end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
        abort_nx = 1'b1;
        state_nx = IDLE;
        tcnt_nx  = '0;
      end else begin
        tcnt_nx = tcnt + TO_W'(1);
      end
    end
  end

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt_nx;
  logic               pop, full, wr_en;

  assign pop   = (fifo_count != '0) && out_ready;
  assign full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);

  always_comb begin
    cnt_nx = fifo_count;
    if (wr_en && !pop)      cnt_nx = fifo_count + CNT_W'(1);
    else if (pop && !wr_en) cnt_nx = fifo_count - CNT_W'(1);
  end

  // Command FIFO; a push into a full FIFO only survives if the head leaves the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      out_valid    <= 1'b0;
      err_overflow <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= cnt_nx;
      out_valid  <= (cnt_nx != '0);
      if (push && !wr_en) err_overflow <= 1'b1;
    end
  end

  assign {out_cmd, out_x1, out_y1, out_x2, out_y2, out_width, out_height} = mem[rd_ptr];

endmodule

// File: tb/tb_cmd_stream_processor.sv
// Directed bench for cmd_stream_processor: expected commands are queued when
// the completing byte is driven and compared when the DUT hands them out.
module tb_cmd_stream_processor;

  localparam int unsigned CW = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_cmd;
  logic [CW-1:0] out_x1, out_y1, out_x2, out_y2, out_width, out_height;
  logic [2:0]  fifo_count;
  logic        busy, err_abort, err_overflow;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  cmd_stream_processor #(.COORD_W(CW), .FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
    .out_x1(out_x1), .out_y1(out_y1), .out_x2(out_x2), .out_y2(out_y2),
    .out_width(out_width), .out_height(out_height),
    .fifo_count(fifo_count), .busy(busy),
    .err_abort(err_abort), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] op(input logic [1:0] c, input logic [4:0] p);
    return {1'b1, c, p};
  endfunction

  function automatic logic [7:0] par(input logic [4:0] p);
    return {1'b1, 2'b00, p};
  endfunction

  function automatic logic [31:0] ent(input logic [1:0] c, input logic [4:0] x1, y1, x2, y2,
                                      w, h);
    return {c, x1, y1, x2, y2, w, h};
  endfunction

  function automatic logic [31:0] head();
    return {out_cmd, out_x1, out_y1, out_x2, out_y2, out_width, out_height};
  endfunction

  function automatic logic [63:0] all_outs();
    return {25'd0, out_valid, fifo_count, busy, err_abort, err_overflow, head()};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one byte for one cycle; pops are scored at the falling edge before the pop edge.
  task automatic step(input logic [7:0] b);
    logic [31:0] e;
    ui_in = b;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_head", 64'(head()), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ui_in = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;

    // LINE with immediate consume
    out_ready = 1'b1;
    step(op(2'b10, 5'd2));
    chk("line_busy", 64'(busy), 64'd1);
    step(par(5'd3));
    step(par(5'd5));
    sb.push_back(ent(2'b10, 5'd2, 5'd3, 5'd5, 5'd6, 5'd0, 5'd0));
    step(par(5'd6));
    chk("line_valid", 64'(out_valid), 64'd1);
    chk("line_count", 64'(fifo_count), 64'd1);
    chk("line_idle", 64'(busy), 64'd0);
    step(8'h00);
    chk("line_popped", 64'(fifo_count), 64'd0);

    // CLEAR and full-width PIXEL
    sb.push_back(32'd0);
    step(op(2'b01, 5'd31));
    chk("clear_count", 64'(fifo_count), 64'd1);
    chk("clear_notbusy", 64'(busy), 64'd0);
    step(8'h00);
    step(op(2'b01, 5'd30));
    sb.push_back(ent(2'b01, 5'd30, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0));
    step(par(5'd7));
    step(8'h00);

    // RECT with wait states under the timeout
    step(op(2'b11, 5'd1));
    step(par(5'd2));
    repeat (10) step(8'h00);
    chk("rect_wait_busy", 64'(busy), 64'd1);
    chk("rect_wait_noabort", 64'(err_abort), 64'd0);
    step(par(5'd4));
    sb.push_back(ent(2'b11, 5'd1, 5'd2, 5'd0, 5'd0, 5'd4, 5'd3));
    step(par(5'd3));
    chk("rect_noabort", 64'(err_abort), 64'd0);
    step(8'h00);

    // RECT timing out
    step(op(2'b11, 5'd1));
    step(par(5'd2));
    repeat (14) step(8'h00);
    chk("to_pre_busy", 64'(busy), 64'd1);
    chk("to_pre_abort", 64'(err_abort), 64'd0);
    step(8'h00);
    chk("to_abort", 64'(err_abort), 64'd1);
    chk("to_busy", 64'(busy), 64'd0);
    step(8'h00);
    chk("to_abort_pulse", 64'(err_abort), 64'd0);
    chk("to_nothing_pushed", 64'(fifo_count), 64'd0);

    // Opcode during LINE aborts it and starts a PIXEL
    step(op(2'b10, 5'd1));
    step(par(5'd2));
    step(op(2'b01, 5'd3));
    chk("abort_pulse", 64'(err_abort), 64'd1);
    chk("abort_busy", 64'(busy), 64'd1);
    sb.push_back(ent(2'b01, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0));
    step(par(5'd4));
    chk("abort_cleared", 64'(err_abort), 64'd0);
    step(8'h00);
    chk("abort_drained", 64'(fifo_count), 64'd0);

    // Fill the FIFO with the consumer stalled, then overflow
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(op(2'b01, 5'(i + 1)));
      sb.push_back(ent(2'b01, 5'(i + 1), 5'(i + 10), 5'd0, 5'd0, 5'd0, 5'd0));
      step(par(5'(i + 10)));
    end
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_no_ovf", 64'(err_overflow), 64'd0);
    step(op(2'b01, 5'd9));
    step(par(5'd9));
    chk("ovf_count", 64'(fifo_count), 64'd4);
    chk("ovf_flag", 64'(err_overflow), 64'd1);
    chk("ovf_head", 64'(head()), 64'(ent(2'b01, 5'd1, 5'd10, 5'd0, 5'd0, 5'd0, 5'd0)));
    step(op(2'b01, 5'd20));
    out_ready = 1'b1;
    sb.push_back(ent(2'b01, 5'd20, 5'd21, 5'd0, 5'd0, 5'd0, 5'd0));
    step(par(5'd21));
    out_ready = 1'b0;
    chk("pushpop_count", 64'(fifo_count), 64'd4);
    chk("ovf_sticky", 64'(err_overflow), 64'd1);

    // Reset mid-LINE with two entries queued
    out_ready = 1'b1;
    repeat (2) step(8'h00);
    out_ready = 1'b0;
    chk("pre_rst_count", 64'(fifo_count), 64'd2);
    step(op(2'b10, 5'd5));
    step(par(5'd6));
    rst_n = 1'b0;
    step(8'h00);
    chk("midrst_outputs", all_outs(), 64'd0);
    sb.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(op(2'b01, 5'd7));
    sb.push_back(ent(2'b01, 5'd7, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0));
    step(par(5'd8));
    chk("post_rst_valid", 64'(out_valid), 64'd1);

    for (int n = 0; n < 20 && sb.size() != 0; n++) step(8'h00);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("final_count", 64'(fifo_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
